// File: rtl/drum_acc.sv
// Frame accumulator for DRUM multiplier products: sums `len` beats and returns one frame total.
// Optional build macro DRUM_ACC_SAT_EN: saturate on carry-out instead of wrapping.
module drum_acc #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [ACC_W:0]   sum_s;
  logic [LEN_W-1:0] count_inc_s;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    sum_s       = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    count_inc_s = count_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          if (len != '0) begin
            len_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          count_d = count_inc_s;
          // sum_s carries one extra bit so carry-out is visible for overflow/saturation
          if (sum_s[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef DRUM_ACC_SAT_EN
            acc_d = '1;
`else
            acc_d = sum_s[ACC_W-1:0];
`endif
          end else begin
            acc_d = sum_s[ACC_W-1:0];
          end
          if (count_inc_s == len_q) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: doc/drum_acc.md
DRUM_ACC -- requirements
Module: drum_acc

Interface
REQ-001 Parameter ACC_W, default 40: accumulator and result width in bits; legal range 32..48.
REQ-002 Parameter LEN_W, default 8: frame-length field width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  frame start request; honoured only in IDLE.
REQ-006 len  input  LEN_W  number of products in the frame; sampled when start is accepted.
REQ-007 in_valid  input  1  in_prod holds a valid product.
REQ-008 in_ready  output  1  block accepts in_prod this cycle.
REQ-009 in_prod  input  32  unsigned product from the upstream 16x16 DRUM multiplier.
REQ-010 out_valid  output  1  out_sum holds a completed frame sum.
REQ-011 out_ready  input  1  downstream consumes out_sum.
REQ-012 out_sum  output  ACC_W  frame sum.
REQ-013 overflow  output  1  at least one addition in the current or last frame carried out of ACC_W bits.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACCUM, DONE.
REQ-016 IDLE: start=1 and len!=0 clears acc, count and overflow, latches len, and moves to ACCUM.
REQ-017 IDLE: start=1 and len==0 clears acc and overflow and moves directly to DONE, producing out_sum=0.
REQ-018 in_ready=1 only in ACCUM; a beat transfers on a cycle where in_valid & in_ready.
REQ-019 Each transfer adds zero-extended in_prod to acc and increments count.
REQ-020 The transfer that brings count to the latched len moves the FSM to DONE; out_valid=1 on the following cycle, so there is one cycle of latency after the last beat.
REQ-021 In ACCUM, in_valid=0 causes a stall: acc and count hold, with no timeout.
REQ-022 DONE: out_valid=1 and out_sum=acc, both held stable until out_ready=1; the transfer returns the FSM to IDLE.
REQ-023 start is ignored outside IDLE; len changes outside the IDLE acceptance edge have no effect.
REQ-024 start asserted in the IDLE cycle immediately after a DONE handshake is accepted normally, giving back-to-back frames.
REQ-025 overflow is sticky within a frame, cleared at frame start, and held through DONE and into IDLE.
REQ-026 out_sum equals acc in all states; it is meaningful only while out_valid=1.

Reset
REQ-027 When rst_n=0 at a clock edge: state=IDLE, acc=0, count=0, out_valid=0, in_ready=0, overflow=0, busy=0.
REQ-028 Reset asserted mid-frame (ACCUM or DONE) aborts the frame; no out_valid is issued for the aborted frame.
REQ-029 in_valid, start and out_ready are ignored during the reset cycle.

Configuration
REQ-030 Macro DRUM_ACC_SAT_EN: when defined, an addition that carries out clamps acc to all ones; further additions keep acc at all ones; overflow is set.
REQ-031 Without DRUM_ACC_SAT_EN: acc wraps modulo 2^ACC_W and overflow is still set on carry-out.

Verification
REQ-032 Basic frame: len=3, products 100, 200, 300 with in_valid held high -> out_valid=1 one cycle after the third beat, out_sum=600, overflow=0.
REQ-033 Stall and backpressure: len=2 with a 5-cycle in_valid gap between beats, then out_ready held low for 4 cycles -> out_sum holds 0x1_0000_0000 when both products are 0x8000_0000, and out_valid stays high for the whole wait.
REQ-034 Zero length and ignored start: len=0 -> out_valid the next cycle with out_sum=0; start pulsed during ACCUM does not disturb acc or count.
REQ-035 Overflow at ACC_W=32: products 0xFFFF_FFFF, 0x2 -> with DRUM_ACC_SAT_EN, out_sum=0xFFFF_FFFF; without it, out_sum=0x1; overflow=1 in both builds.
REQ-036 Reset mid-frame: rst_n low for one cycle after 2 of 4 beats -> state IDLE, out_valid never asserts; a new len=1 frame with product 7 gives out_sum=7.
REQ-037 Back-to-back frames: start asserted in the cycle after a DONE handshake -> the second frame accepts its first beat with no idle bubble beyond the IDLE cycle.
